// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and busy scoreboard
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_WR-1:0]        bset,
    input  logic [NUM_WR*ADDR_W-1:0] bset_addr,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [NUM_WR-1:0] wr_ok, bset_ok;

    // Per-port qualification: register 0 is untouchable when ZERO_REG is set.
    always_comb begin
        wr_ok   = '0;
        bset_ok = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok[j]   = we[j] &&
                         !((ZERO_REG == 1) && (waddr[j*ADDR_W +: ADDR_W] == '0));
            bset_ok[j] = bset[j] &&
                         !((ZERO_REG == 1) && (bset_addr[j*ADDR_W +: ADDR_W] == '0));
        end
    end

    // Ascending port order lets the highest-index writer land last and win.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                rf_q[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j]) begin
                    rf_q[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) begin
                busy_d[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (bset_ok[j]) begin
                busy_d[bset_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdata[k*DATA_W +: DATA_W] = rf_q[raddr[k*ADDR_W +: ADDR_W]];
            rbusy[k]                  = busy_q[raddr[k*ADDR_W +: ADDR_W]];
            if (BYPASS == 1) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_ok[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr[k*ADDR_W +: ADDR_W])) begin
                        rdata[k*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
                        rbusy[k]                  = 1'b0;
                    end
                end
            end
            if ((ZERO_REG == 1) && (raddr[k*ADDR_W +: ADDR_W] == '0)) begin
                rdata[k*DATA_W +: DATA_W] = '0;
                rbusy[k]                  = 1'b0;
            end
        end
    end

    always_comb begin
        dbg_data = rf_q[dbg_addr];
        if ((ZERO_REG == 1) && (dbg_addr == '0)) begin
            dbg_data = '0;
        end
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the dual-issue pipeline; successor to the single-issue 2R1W file. Provides NUM_RD combinational read ports, NUM_WR write ports with deterministic conflict priority, and optional write-to-read bypass. Includes a per-register busy scoreboard that issue logic sets and writeback clears. Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 4, number of read ports
NUM_WR, 2, number of write ports, and number of busy-set ports
BYPASS, 1, 1 = same-cycle write data/clear forwarded to reads; 0 = reads see registered state only
ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
raddr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
rbusy  out  NUM_RD  busy bit of the register addressed by read port k
we  in  NUM_WR  write enable per write port, high valid
waddr  in  NUM_WR*ADDR_W  write addresses
wdata  in  NUM_WR*DATA_W  write data
bset  in  NUM_WR  busy-set strobe per issue slot
bset_addr  in  NUM_WR*ADDR_W  destination register to mark busy
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  registered-state value of dbg_addr (never bypassed)

Behaviour:
- Reset: on a rising edge with reset=1, all registers are cleared to 0 and all busy bits to 0; reset dominates we and bset in the same cycle. Outputs are combinational, so after reset every rdata = 0, rbusy = 0, dbg_data = 0.
- Write: at the rising edge, for each port j with we[j]=1, rf[waddr_j] <= wdata_j. Writes to address 0 are dropped when ZERO_REG=1.
- Write conflict: when several enabled ports target the same address, the highest-index port wins. Other addresses are written independently in the same cycle.
- Read: latency is 0 (combinational from raddr). With ZERO_REG=1, raddr=0 returns 0 and rbusy=0.
- Bypass (BYPASS=1): if any enabled write port targets raddr_k (and the address is non-zero under ZERO_REG), rdata_k equals that port's wdata, with highest index winning. With BYPASS=0, rdata_k returns the pre-edge stored value.
- Busy scoreboard:
  - At the edge, busy[r] is cleared by any enabled write to r and set by any bset to r.
  - Set wins over clear for the same register in the same cycle, because the new producer supersedes the retiring one.
  - bset to register 0 is ignored under ZERO_REG=1. Duplicate bset addresses are harmless.
- rbusy with BYPASS=1: rbusy_k = busy[raddr_k] AND NOT (any same-cycle enabled write to raddr_k). Same-cycle bset is not forwarded. With BYPASS=0, rbusy_k = busy[raddr_k].
- Reads on any number of ports may alias each other and the write ports freely; no structural hazards.
- Widths: all ports are fixed-width slices; there is no sign extension or truncation.

Test Plan:
- Reset with preloaded state: write 0xDEADBEEF to r5, assert reset for 1 cycle while also we=1 to r6 -> next cycle rdata(r5)=0, rdata(r6)=0, all rbusy=0.
- Dual write conflict: we=2'b11, waddr both =7, wdata0=0x11111111, wdata1=0x22222222 -> after edge rdata(r7)=0x22222222. Repeat with different addresses 3 and 4 -> both written.
- Bypass: BYPASS=1, r9 holds 0x5, same cycle we0=1 waddr=9 wdata=0xA with raddr0=9 -> rdata0=0xA combinationally. With BYPASS=0 -> rdata0=0x5, then 0xA next cycle.
- Zero register: write 0xFFFFFFFF to r0 and bset r0 -> rdata(r0)=0, rbusy=0 forever.
- Scoreboard: bset r12 -> next cycle rbusy=1. Then we to r12 and bset r12 in the same cycle -> rbusy stays 1. Then we only -> rbusy=0 (0 in the write cycle itself when BYPASS=1).
- All-port read: NUM_RD=4 reading r1..r4 preloaded with 1..4 -> rdata = {4,3,2,1} in packed order. dbg_addr=3 -> dbg_data=3.
